// File: rtl/rega_sequenciador_if.sv
// Request/actuator bundle between the irrigation decision logic and the sequencer.
// The sequencer sits on the slave side and drives the actuators and status.
interface rega_sequenciador_if;
  logic       Bs_req;
  logic       Vs_req;
  logic       ERRO;
  logic       Rearme;
  logic       Bs;
  logic       Vs;
  logic       Alarme;
  logic [2:0] Estado;

  modport master (
    output Bs_req, Vs_req, ERRO, Rearme,
    input  Bs, Vs, Alarme, Estado
  );

  modport slave (
    input  Bs_req, Vs_req, ERRO, Rearme,
    output Bs, Vs, Alarme, Estado
  );
endinterface

// File: rtl/rega_sequenciador.sv
// Sequencer/arbiter sharing one water line between sprinkler pump and drip valve,
// with minimum run, dead time, maximum run timeout and latched faults.
module rega_sequenciador #(
  parameter int CW     = 8,
  parameter int TMIN   = 8,
  parameter int TPAUSE = 4,
  parameter int TMAX   = 64
) (
  input logic                 clk,
  input logic                 rst,
  rega_sequenciador_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ASP   = 3'd1,
    GOT   = 3'd2,
    PAUSA = 3'd3,
    FALHA = 3'd4
  } state_e;

  localparam logic [CW-1:0] MIN_LAST   = CW'(TMIN - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(TMAX - 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(TPAUSE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ultimo_q, ultimo_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ultimo_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ultimo_q <= ultimo_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    ultimo_d = ultimo_q;

    if (bus.ERRO && state_q != FALHA) begin
      state_d = FALHA;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Bs_req && bus.Vs_req) state_d = ultimo_q ? ASP : GOT;
          else if (bus.Bs_req)          state_d = ASP;
          else if (bus.Vs_req)          state_d = GOT;
        end
        ASP: begin
          if (cnt_q >= MIN_LAST && !bus.Bs_req) state_d = PAUSA;
          else if (cnt_q == MAX_LAST)           state_d = FALHA;
        end
        GOT: begin
          if (cnt_q >= MIN_LAST && !bus.Vs_req) state_d = PAUSA;
          else if (cnt_q == MAX_LAST)           state_d = FALHA;
        end
        PAUSA: begin
          if (cnt_q == PAUSE_LAST) state_d = IDLE;
        end
        FALHA: begin
          if (!bus.ERRO && bus.Rearme) state_d = PAUSA;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q && state_d == ASP) ultimo_d = 1'b0;
    if (state_d != state_q && state_d == GOT) ultimo_d = 1'b1;

    // IDLE and FALHA may be held indefinitely; saturate rather than wrap there.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == '1)    cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_ONE;
  end

  always_comb begin
    bus.Bs     = (state_q == ASP);
    bus.Vs     = (state_q == GOT);
    bus.Alarme = (state_q == FALHA);
    bus.Estado = state_q;
  end

endmodule

// File: tb/tb_rega_sequenciador.sv
// Self-checking bench for rega_sequenciador: vector table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_rega_sequenciador;

  localparam int TMIN   = 8;
  localparam int TPAUSE = 4;
  localparam int TMAX   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rega_sequenciador_if bus ();

  rega_sequenciador #(.CW(8), .TMIN(TMIN), .TPAUSE(TPAUSE), .TMAX(TMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state code, cycles spent in current state, last served.
  int m_state, m_cnt, m_last;

  typedef struct packed {
    bit       bs, vs, er, rm;
    bit [2:0] est;
    bit       b, v, al;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_last = 1;
  endtask

  task automatic model_step(input bit bs, input bit vs, input bit er, input bit rm);
    int nxt;
    nxt = m_state;
    if (er && m_state != 4) nxt = 4;
    else if (m_state == 0) begin
      if (bs && vs)  nxt = (m_last == 1) ? 1 : 2;
      else if (bs)   nxt = 1;
      else if (vs)   nxt = 2;
    end else if (m_state == 1 || m_state == 2) begin
      if (m_cnt >= TMIN - 1 && !(m_state == 1 ? bs : vs)) nxt = 3;
      else if (m_cnt == TMAX - 1)                           nxt = 4;
    end else if (m_state == 3) begin
      if (m_cnt == TPAUSE - 1) nxt = 0;
    end else if (m_state == 4) begin
      if (!er && rm) nxt = 3;
    end
    if (nxt != m_state) begin
      m_cnt = 0;
      if (nxt == 1) m_last = 0;
      if (nxt == 2) m_last = 1;
    end else begin
      m_cnt++;
    end
    m_state = nxt;
  endtask

  function automatic logic [5:0] dut_out();
    return {bus.Estado, bus.Bs, bus.Vs, bus.Alarme};
  endfunction

  function automatic logic [5:0] model_out();
    logic [2:0] e;
    e = 3'(m_state);
    return {e, m_state == 1, m_state == 2, m_state == 4};
  endfunction

  task automatic cycle(input bit bs, input bit vs, input bit er, input bit rm);
    bus.Bs_req = bs; bus.Vs_req = vs; bus.ERRO = er; bus.Rearme = rm;
    @(posedge clk);
    model_step(bs, vs, er, rm);
    #1;
    check("model_cmp", 32'(dut_out()), 32'(model_out()));
    if (bus.Bs && bus.Vs) check("bs_vs_exclusive", 32'(1), 32'(0));
  endtask

  task automatic do_reset();
    bus.Bs_req = 0; bus.Vs_req = 0; bus.ERRO = 0; bus.Rearme = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_out()), 32'(6'b000_000));
    rst = 1'b0;
  endtask

  vec_t vecs[13];
  int   n_bs, n_vs, n_pausa, n_idle, n_got;

  initial begin
    vecs[0]  = '{1,0,0,0, 3'd1, 1,0,0};
    vecs[1]  = '{1,0,0,0, 3'd1, 1,0,0};
    vecs[2]  = '{1,0,0,0, 3'd1, 1,0,0};
    vecs[3]  = '{0,0,1,0, 3'd4, 0,0,1};  // fault overrides minimum run
    vecs[4]  = '{0,0,1,1, 3'd4, 0,0,1};  // re-arm ignored while ERRO
    vecs[5]  = '{0,0,0,0, 3'd4, 0,0,1};
    vecs[6]  = '{0,0,0,1, 3'd3, 0,0,0};
    vecs[7]  = '{1,1,0,0, 3'd3, 0,0,0};
    vecs[8]  = '{1,1,0,0, 3'd3, 0,0,0};
    vecs[9]  = '{1,1,0,0, 3'd3, 0,0,0};
    vecs[10] = '{1,1,0,0, 3'd0, 0,0,0};
    vecs[11] = '{1,1,0,0, 3'd2, 0,1,0};  // tie goes to the one not served last
    vecs[12] = '{0,1,1,0, 3'd4, 0,0,1};

    // Vector table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.Bs_req = vecs[i].bs; bus.Vs_req = vecs[i].vs;
      bus.ERRO = vecs[i].er;   bus.Rearme = vecs[i].rm;
      @(posedge clk);
      model_step(vecs[i].bs, vecs[i].vs, vecs[i].er, vecs[i].rm);
      #1;
      check($sformatf("vec%0d", i), 32'(dut_out()),
            32'({vecs[i].est, vecs[i].b, vecs[i].v, vecs[i].al}));
    end

    // Short request: minimum run then dead time
    do_reset();
    n_bs = 0; n_vs = 0; n_pausa = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(i < 3, 0, 0, 0);
      n_bs += int'(bus.Bs); n_vs += int'(bus.Vs); n_pausa += int'(bus.Estado == 3'd3);
    end
    check("minrun_bs_cycles", 32'(n_bs), 32'(8));
    check("minrun_pausa_cycles", 32'(n_pausa), 32'(4));
    check("minrun_vs_never", 32'(n_vs), 32'(0));

    // Contention: long ASP run, then the waiting valve is served
    do_reset();
    n_bs = 0; n_pausa = 0; n_idle = 0; n_got = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(i < 21, 1, 0, 0);
      n_bs += int'(bus.Bs); n_pausa += int'(bus.Estado == 3'd3);
      n_idle += int'(bus.Estado == 3'd0); n_got += int'(bus.Vs);
    end
    check("tie_asp_cycles", 32'(n_bs), 32'(21));
    check("tie_pausa_cycles", 32'(n_pausa), 32'(4));
    check("tie_idle_cycles", 32'(n_idle), 32'(1));
    check("tie_got_cycles", 32'(n_got), 32'(10));

    // Timeout, then re-arm handling
    do_reset();
    n_vs = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(0, 1, 0, 0);
      n_vs += int'(bus.Vs);
    end
    check("timeout_vs_cycles", 32'(n_vs), 32'(TMAX));
    check("timeout_state", 32'(dut_out()), 32'(6'b100_001));
    cycle(0, 0, 1, 1);
    check("rearme_blocked", 32'(bus.Estado), 32'(4));
    cycle(0, 0, 0, 1);
    n_pausa = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      n_pausa += int'(bus.Estado == 3'd3);
    end
    check("rearme_pausa_cycles", 32'(n_pausa), 32'(4));
    check("rearme_idle", 32'(dut_out()), 32'(6'b000_000));

    // Asynchronous reset mid-run
    do_reset();
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 0);
    check("pre_rst_got", 32'(dut_out()), 32'(6'b010_010));
    #1 rst = 1'b1;
    #1 check("async_rst", 32'(dut_out()), 32'(6'b000_000));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(1, 1, 0, 0);
    check("post_rst_tie_asp", 32'(bus.Estado), 32'(1));

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
